// File: rtl/pc_fetch_unit_pkg.sv
// Shared types for the PC/fetch block: fetch FSM encoding and reset-PC default.
package pc_fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_ERR
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Purpose: owns the architectural PC, issues IMEM fetches and holds the fetched word for decode.
// Latency: request accepted at t, response at t+1, inst_valid at t+2; one instruction per 3 cycles.
// Backpressure: request held stable until imem_req_ready; instruction held until inst_ready.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      pc,
    input  logic [31:0]      npc,
    output logic             imem_req_valid,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired_cnt
);

    fetch_state_t state;

    assign imem_req_addr = pc;

    // Valids and the error flag are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            inst           <= 32'h0;
            inst_pc        <= 32'h0;
            retired_cnt    <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            misalign_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state          <= ST_REQ;
                    imem_req_valid <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state          <= ST_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst       <= imem_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        pc          <= npc;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                        inst_valid  <= 1'b0;
                        if (is_misaligned(npc)) begin
                            state        <= ST_ERR;
                            misalign_err <= 1'b1;
                        end else begin
                            state          <= ST_REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    // Terminal until reset: no fetches, nothing presented to decode.
                    state <= ST_ERR;
                end
                default: begin
                    state          <= ST_IDLE;
                    imem_req_valid <= 1'b0;
                    inst_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;
    logic [31:0] retired_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .npc            (npc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .misalign_err   (misalign_err),
        .retired_cnt    (retired_cnt)
    );

    typedef struct {
        logic        rst;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        inst_ready;
        logic [31:0] npc;
        logic [31:0] e_pc;
        logic        e_rv;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic [31:0] n,
                       input logic [31:0] epc, input logic erv, input logic eiv,
                       input logic [31:0] einst, input logic [31:0] eipc,
                       input logic eerr, input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.req_ready = rdy; v.rsp_valid = rv; v.rsp_data = rd;
        v.inst_ready = ir; v.npc = n;
        v.e_pc = epc; v.e_rv = erv; v.e_iv = eiv; v.e_inst = einst;
        v.e_ipc = eipc; v.e_err = eerr; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic ir, input logic [31:0] n);
        rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        inst_ready = ir; npc = n;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic erv,
                           input logic eiv, input logic [31:0] einst, input logic [31:0] eipc,
                           input logic eerr, input logic [31:0] ecnt);
        chk({tag, ".pc"},        pc,                    epc);
        chk({tag, ".req_addr"},  imem_req_addr,         epc);
        chk({tag, ".req_valid"}, {31'h0, imem_req_valid}, {31'h0, erv});
        chk({tag, ".inst_vld"},  {31'h0, inst_valid},   {31'h0, eiv});
        chk({tag, ".inst"},      inst,                  einst);
        chk({tag, ".inst_pc"},   inst_pc,               eipc);
        chk({tag, ".err"},       {31'h0, misalign_err}, {31'h0, eerr});
        chk({tag, ".cnt"},       retired_cnt,           ecnt);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //   rst rdy rsp data          ird npc            | pc          rv iv inst          ipc          err cnt
        add(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,    0, 0, 32'h0,        32'h0,    0, 0); // reset
        add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,    1, 0, 32'h0,        32'h0,    0, 0); // IDLE->REQ
        add(0, 1, 0, 32'h0,        0, 32'h0,        32'h0,    0, 0, 32'h0,        32'h0,    0, 0); // ->WAIT
        add(0, 0, 1, 32'h13,       0, 32'h0,        32'h0,    0, 1, 32'h13,       32'h0,    0, 0); // ->HOLD
        add(0, 0, 0, 32'h0,        0, 32'h4,        32'h0,    0, 1, 32'h13,       32'h0,    0, 0); // hold stable
        add(0, 0, 0, 32'h0,        1, 32'h4,        32'h4,    1, 0, 32'h13,       32'h0,    0, 1); // retire
        add(0, 1, 0, 32'h0,        0, 32'h4,        32'h4,    0, 0, 32'h13,       32'h0,    0, 1);
        add(0, 0, 1, 32'h00400093, 0, 32'h8,        32'h4,    0, 1, 32'h00400093, 32'h4,    0, 1);
        add(0, 0, 0, 32'h0,        1, 32'h8,        32'h8,    1, 0, 32'h00400093, 32'h4,    0, 2);
        add(0, 1, 0, 32'h0,        0, 32'h8,        32'h8,    0, 0, 32'h00400093, 32'h4,    0, 2);
        add(0, 0, 1, 32'h00100113, 0, 32'hC,        32'h8,    0, 1, 32'h00100113, 32'h8,    0, 2);
        add(0, 0, 0, 32'h0,        1, 32'hC,        32'hC,    1, 0, 32'h00100113, 32'h8,    0, 3);
        // IMEM stalls five cycles; a stray response outside WAIT must be ignored.
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 32'hDEADBEEF, 0, 32'h0,    32'hC,    1, 0, 32'h00100113, 32'h8,    0, 3);
        add(0, 1, 0, 32'h0,        0, 32'h0,        32'hC,    0, 0, 32'h00100113, 32'h8,    0, 3);
        add(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,    0, 0, 32'h00100113, 32'h8,    0, 3); // late rsp
        add(0, 0, 1, 32'h0000AAAA, 0, 32'h3000,     32'hC,    0, 1, 32'h0000AAAA, 32'hC,    0, 3);
        add(0, 0, 0, 32'h0,        1, 32'h3000,     32'h3000, 1, 0, 32'h0000AAAA, 32'hC,    0, 4);
        add(0, 1, 0, 32'h0,        0, 32'h3000,     32'h3000, 0, 0, 32'h0000AAAA, 32'hC,    0, 4);
        add(0, 0, 1, 32'hFE000EE3, 0, 32'h2FF0,     32'h3000, 0, 1, 32'hFE000EE3, 32'h3000, 0, 4);
        add(0, 0, 0, 32'h0,        1, 32'h2FF0,     32'h2FF0, 1, 0, 32'hFE000EE3, 32'h3000, 0, 5); // back branch
        add(0, 1, 0, 32'h0,        1, 32'h9990,     32'h2FF0, 0, 0, 32'hFE000EE3, 32'h3000, 0, 5); // ird ignored
        add(0, 0, 1, 32'h00000063, 0, 32'h2002,     32'h2FF0, 0, 1, 32'h00000063, 32'h2FF0, 0, 5);
        add(0, 0, 0, 32'h0,        1, 32'h2002,     32'h2002, 0, 0, 32'h00000063, 32'h2FF0, 1, 6); // misaligned
        add(0, 1, 1, 32'h11111111, 1, 32'h8,        32'h2002, 0, 0, 32'h00000063, 32'h2FF0, 1, 6);
        add(0, 1, 1, 32'h22222222, 1, 32'hC,        32'h2002, 0, 0, 32'h00000063, 32'h2FF0, 1, 6);
        add(1, 1, 1, 32'h33333333, 1, 32'h10,       32'h0,    0, 0, 32'h0,        32'h0,    0, 0); // rst exits ERR
        add(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,    1, 0, 32'h0,        32'h0,    0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req_ready, vecs[i].rsp_valid, vecs[i].rsp_data,
                  vecs[i].inst_ready, vecs[i].npc);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_rv, vecs[i].e_iv,
                    vecs[i].e_inst, vecs[i].e_ipc, vecs[i].e_err, vecs[i].e_cnt);
        end

        // Reset while in WAIT, then a stray response during IDLE: nothing is captured.
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        step();
        chk_all("wait", 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        step();
        chk_all("rst_in_wait", 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        drive(0, 0, 1, 32'hBADBAD00, 0, 32'h0);
        step();
        chk_all("stray_rsp", 32'h0, 1, 0, 32'h0, 32'h0, 0, 0);

        // Restart fetch from RESET_PC; bounded wait for the instruction to appear.
        begin
            bit seen = 1'b0;
            drive(0, 1, 0, 32'h0, 0, 32'h0);
            step();
            drive(0, 0, 1, 32'h00500193, 0, 32'h40);
            for (int c = 0; c < 10 && !seen; c++) begin
                step();
                if (inst_valid) seen = 1'b1;
            end
            chk("restart.seen", {31'h0, seen}, 32'h1);
            chk_all("restart", 32'h0, 0, 1, 32'h00500193, 32'h0, 0, 0);
        end

        // Reset wins over a retire in HOLD: counter and PC are not advanced.
        drive(1, 0, 0, 32'h0, 1, 32'h40);
        step();
        chk_all("rst_vs_retire", 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
